// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: default exponent geometry,
// legal-range helpers and the exponent result bundle.
package fp_pkg;

    localparam int EXP_W_DEF = 4;
    localparam int BIAS_DEF  = 7;
    localparam int EXP_W_MAX = 16;

    // Exponent field is sized for the widest supported format; narrower users take the low bits.
    typedef struct packed {
        logic [EXP_W_MAX-1:0] exponente;
        logic                 overflow;
        logic                 underflow;
    } exp_result_t;

    function automatic int exp_min(input int reserved);
        return (reserved != 0) ? 1 : 0;
    endfunction

    function automatic int exp_max(input int exp_w, input int reserved);
        return (1 << exp_w) - ((reserved != 0) ? 2 : 1);
    endfunction

endpackage

// File: rtl/exp_rango_check.sv
// Range check of an unbiased exponent difference: raises overflow/underflow
// and optionally clamps the exponent to the representable range.
module exp_rango_check
    import fp_pkg::*;
#(
    parameter int EXP_W    = EXP_W_DEF,
    parameter int RESERVED = 0,
    parameter int SATURATE = 1
) (
    input  logic signed [EXP_W+1:0] diff,
    output exp_result_t             resultado
);

    localparam logic signed [EXP_W+1:0] MIN_S  = (EXP_W+2)'(exp_min(RESERVED));
    localparam logic signed [EXP_W+1:0] MAX_S  = (EXP_W+2)'(exp_max(EXP_W, RESERVED));
    // With reserved codes an overflow maps to the all-ones infinity code rather than MAX.
    localparam logic [EXP_W-1:0]        SAT_HI = (RESERVED != 0) ? '1 : MAX_S[EXP_W-1:0];

    logic             overflow;
    logic             underflow;
    logic [EXP_W-1:0] exp_v;

    always_comb begin
        overflow  = diff > MAX_S;
        underflow = diff < MIN_S;
        exp_v     = diff[EXP_W-1:0];
        if (SATURATE != 0) begin
            if (overflow) begin
                exp_v = SAT_HI;
            end else if (underflow) begin
                exp_v = '0;
            end
        end
        resultado           = '0;
        resultado.exponente = EXP_W_MAX'(exp_v);
        resultado.overflow  = overflow;
        resultado.underflow = underflow;
    end

endmodule

// File: rtl/sumador_exponente_pipe.sv
// Two-stage valid/ready exponent adder: e1 + e2 + carry - BIAS with
// range flags and optional saturation for the multiplier datapath.
module sumador_exponente_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W    = EXP_W_DEF,
    parameter int BIAS     = BIAS_DEF,
    parameter int RESERVED = 0,
    parameter int SATURATE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [EXP_W-1:0] i_exponente_1,
    input  logic [EXP_W-1:0] i_exponente_2,
    input  logic             i_carry_exponente,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [EXP_W-1:0] o_exponente,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int SW = EXP_W + 2;

    logic                 s1_valid;
    logic [SW-1:0]        s1_sum;
    logic                 s2_valid;
    logic                 s1_load;
    logic                 s2_load;
    logic signed [SW-1:0] diff;
    exp_result_t          res;
    logic                 unused_hi;

    // Two extra bits keep the full sum and the signed difference free of wrap.
    assign diff      = $signed(s1_sum - SW'(BIAS));
    assign s2_load   = !s2_valid || i_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign o_ready   = s1_load;
    assign o_valid   = s2_valid;
    assign unused_hi = ^res.exponente;

    exp_rango_check #(
        .EXP_W    (EXP_W),
        .RESERVED (RESERVED),
        .SATURATE (SATURATE)
    ) u_rango (
        .diff      (diff),
        .resultado (res)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid    <= 1'b0;
            s1_sum      <= '0;
            s2_valid    <= 1'b0;
            o_exponente <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    o_exponente <= res.exponente[EXP_W-1:0];
                    o_overflow  <= res.overflow;
                    o_underflow <= res.underflow;
                end
            end
            if (s1_load) begin
                s1_valid <= i_valid;
                if (i_valid) begin
                    s1_sum <= SW'(i_exponente_1) + SW'(i_exponente_2) + SW'(i_carry_exponente);
                end
            end
        end
    end

endmodule

// File: doc/sumador_exponente_pipe.md
Name: sumador_exponente_pipe

Overview:
- Parametrised, pipelined exponent adder for the floating-point multiplier datapath.
- Computes e1 + e2 + carry - BIAS for generic exponent width.
- Detects overflow and underflow against the representable range, and optionally saturates.
- Moves operands through a 2-stage valid/ready pipeline so the mantissa path can apply backpressure.

Parameters:
- EXP_W, 4, exponent width in bits (>= 2).
- BIAS, 7, exponent bias; must satisfy 0 <= BIAS <= 2^EXP_W-1.
- RESERVED, 0, 1 reserves all-zeros and all-ones codes, giving legal range [1, 2^EXP_W-2]; 0 gives legal range [0, 2^EXP_W-1].
- SATURATE, 1, 1 clamps out-of-range results; 0 outputs the raw low EXP_W bits.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept operands this cycle.
- i_exponente_1  in  EXP_W  first biased exponent.
- i_exponente_2  in  EXP_W  second biased exponent.
- i_carry_exponente  in  1  mantissa normalisation carry, added as +1.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_exponente  out  EXP_W  result exponent.
- o_overflow  out  1  true result > max legal.
- o_underflow  out  1  true result < min legal.

Behaviour:
- Reset: both stage valid bits are cleared. o_valid=0, o_exponente=0, o_overflow=0, o_underflow=0. o_ready=1 in the cycle after reset deasserts. Reset has priority over everything and discards in-flight data mid-operation.
- Handshake:
  - An input transfer occurs on i_valid & o_ready.
  - An output transfer occurs on o_valid & i_ready.
  - o_valid, o_exponente and the flags hold stable while o_valid=1 and i_ready=0.
- Stage 1 register:
  - s1_sum = e1 + e2 + carry, zero-extended to EXP_W+2 bits, unsigned, no loss.
  - s1_valid is set on an input transfer.
- Stage 2 register:
  - diff = s1_sum - BIAS in EXP_W+2-bit two's complement, signed.
  - MIN = RESERVED ? 1 : 0. MAX = RESERVED ? 2^EXP_W-2 : 2^EXP_W-1.
  - overflow = diff > MAX (signed compare). underflow = diff < MIN (signed compare).
  - Exponent when SATURATE=1:
    - overflow: output all ones if RESERVED=1 (infinity code), else MAX.
    - underflow: output 0.
    - otherwise: diff[EXP_W-1:0].
  - Exponent when SATURATE=0: always diff[EXP_W-1:0]. Flags are still reported.
- Advance rules:
  - s2 loads from s1 when (!s2_valid | i_ready).
  - s1 loads when (!s1_valid | s2 loads).
  - o_ready = !s1_valid | s2 loads (combinational from i_ready, no registered skid).
- Latency and throughput:
  - With i_ready=1, a result appears 2 cycles after the input transfer.
  - Throughput is 1 per cycle.
  - Full pipeline stall holds 2 items without loss or duplication.
- Simultaneous input and output transfer in the same cycle with both stages full: both shift and the pipeline stays full.
- Boundary cases:
  - e1=e2=all-ones, carry=1: no internal wrap, because EXP_W+2 bits cover the sum.
  - diff exactly MIN or MAX: legal, no flag raised.

Decomposition:
- Shared package fp_pkg holds:
  - default EXP_W/BIAS constants,
  - functions exp_min(RESERVED) and exp_max(EXP_W, RESERVED),
  - a result struct {exponent, overflow, underflow}, for reuse by the mantissa normaliser and the top level.
- One natural sub-module, exp_rango_check: combinational diff -> {exponent, overflow, underflow} with range and saturation logic. It is instantiated in stage 2.
- Pipeline and handshake logic stay in the top of this block.

Test Plan (EXP_W=4, BIAS=7, RESERVED=0, SATURATE=1 unless noted):
- 5+6, carry 0, i_ready=1 -> 2 cycles later o_exponente=4, flags 0. Then 7+7, carry 1 back-to-back -> next cycle o_exponente=8.
- 14+14, carry 0 -> diff 21 -> o_exponente=15, o_overflow=1. Same input with SATURATE=0 -> o_exponente=5, o_overflow=1.
- 1+2, carry 0 -> diff -4 -> o_exponente=0, o_underflow=1. 3+4 -> 0 exactly, no flags. RESERVED=1 -> 3+4 gives 0 with underflow=1.
- Backpressure: stream 4 operands with i_ready=0 for 5 cycles -> o_ready drops after 2 accepted, o_exponente stable. On release, results come out in order with no loss or duplication.
- Reset mid-operation: 2 items in flight, assert i_rst 1 cycle -> next cycle o_valid=0 and outputs 0. The next input yields only its own result.
- Random stream with random i_valid/i_ready versus a scoreboard model for EXP_W=8, BIAS=127, RESERVED=1 -> all results and flags match.
